// File: rtl/switch_debouncer_if.sv
// switch_debouncer_if
//   Groups the switch-side and core-side signals of the debouncer.
//   Ports carried:
//     raw_switch  WIDTH  asynchronous switch pin levels
//     switch_out  WIDTH  debounced level
//     rise        WIDTH  one-cycle pulse when a switch_out bit goes 0->1
//     fall        WIDTH  one-cycle pulse when a switch_out bit goes 1->0
//     changed     1      OR of all rise/fall bits
//   Modports:
//     master  drives raw_switch and observes the conditioned outputs
//     slave   the debouncer itself
interface switch_debouncer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] raw_switch;
  logic [WIDTH-1:0] switch_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;

  modport master (
    output raw_switch,
    input  switch_out,
    input  rise,
    input  fall,
    input  changed
  );

  modport slave (
    input  raw_switch,
    output switch_out,
    output rise,
    output fall,
    output changed
  );
endinterface

// File: rtl/switch_debouncer.sv
// switch_debouncer
//   Conditions raw switch pins into clean levels and single-cycle edge events.
//   Each bit passes through a SYNC_STAGES flip-flop synchronizer and then a
//   stability counter: a new level is accepted only after STABLE_CYCLES
//   consecutive synchronized samples that differ from the current output.
//   Ports:
//     clock    system clock, all logic on the rising edge
//     n_reset  synchronous, active-low reset
//     sw       switch_debouncer_if.slave (raw_switch in; switch_out, rise,
//              fall, changed out)
//   Build option:
//     SWITCH_DEBOUNCE_EDGE_EN  when defined, registered rise/fall/changed
//                              pulses are produced; otherwise they are tied
//                              to 0 and no edge registers are built.
module switch_debouncer #(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 65536
) (
  input  logic               clock,
  input  logic               n_reset,
  switch_debouncer_if.slave  sw
);

  localparam int            CW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] accept;
  state_t           state_q [WIDTH];
  state_t           state_d [WIDTH];
  logic [CW-1:0]    cnt_q   [WIDTH];
  logic [CW-1:0]    cnt_d   [WIDTH];

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= sw.raw_switch;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Per-bit FSM. The counter records how many differing samples have been
  // seen; the sample that finds it at LAST is the accepting one, so a bit in
  // STABLE accepts immediately only when STABLE_CYCLES is 1.
  always_comb begin
    out_d  = out_q;
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        STABLE: begin
          cnt_d[i] = '0;
          if (sync_s[i] != out_q[i]) begin
            if (LAST == '0) begin
              accept[i] = 1'b1;
            end else begin
              cnt_d[i]   = CW'(1);
              state_d[i] = PENDING;
            end
          end
        end
        PENDING: begin
          if (sync_s[i] == out_q[i]) begin
            cnt_d[i]   = '0;
            state_d[i] = STABLE;
          end else if (cnt_q[i] == LAST) begin
            accept[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          cnt_d[i]   = '0;
          state_d[i] = STABLE;
        end
      endcase
      if (accept[i]) begin
        out_d[i]   = sync_s[i];
        cnt_d[i]   = '0;
        state_d[i] = STABLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      out_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      out_q <= out_d;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign sw.switch_out = out_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic             changed_q;

  // Pulses are registered alongside out_q so they line up with the first
  // cycle of the new level; the accepted value is sync_s, so its polarity
  // tells rise from fall.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      rise_q    <= accept & sync_s;
      fall_q    <= accept & ~sync_s;
      changed_q <= |accept;
    end
  end

  assign sw.rise    = rise_q;
  assign sw.fall    = fall_q;
  assign sw.changed = changed_q;
`else
  assign sw.rise    = '0;
  assign sw.fall    = '0;
  assign sw.changed = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer
//   Directed bench for switch_debouncer with SYNC_STAGES=2, STABLE_CYCLES=4
//   and a 10 ns clock. Expected pulse values follow SWITCH_DEBOUNCE_EDGE_EN:
//   with the macro undefined, rise/fall/changed must stay 0 while switch_out
//   timing is unchanged.
module tb_switch_debouncer;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clock;
  logic n_reset;
  int   vectors;
  int   miscompares;

  switch_debouncer_if #(.WIDTH(4)) sw_if ();

  switch_debouncer #(
    .WIDTH        (4),
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4)
  ) dut (
    .clock  (clock),
    .n_reset(n_reset),
    .sw     (sw_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic [3:0] raw, input logic rst_n);
    sw_if.raw_switch = raw;
    n_reset          = rst_n;
  endtask

  // Advance n rising edges, leaving time 1 ns past the last edge so outputs
  // are sampled away from the edge and new inputs land before the next one.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin : main
    logic [3:0] seen_out;
    logic [3:0] seen_rise;
    logic [3:0] seen_fall;
    int         rise_count;
    int         rise_step;
    int         out_step;

    vectors     = 0;
    miscompares = 0;

    // Scenario 1: one reset edge with all switches high
    applyStimulus(4'hF, 1'b0);
    #1;
    tick(1);
    applyStimulus(4'hF, 1'b1);
    checkOutput("reset_switch_out", sw_if.switch_out, 4'h0);
    checkOutput("reset_rise", sw_if.rise, 4'h0);
    checkOutput("reset_fall", sw_if.fall, 4'h0);
    checkOutput("reset_changed", sw_if.changed, 1'b0);
    tick(5);
    checkOutput("s1_before_accept", sw_if.switch_out, 4'h0);
    tick(1);
    checkOutput("s1_switch_out", sw_if.switch_out, 4'hF);
    checkOutput("s1_rise", sw_if.rise, EDGE ? 4'hF : 4'h0);
    checkOutput("s1_changed", sw_if.changed, EDGE);
    tick(1);
    checkOutput("s1_rise_one_cycle", sw_if.rise, 4'h0);

    // Release all switches and check the fall pulse
    applyStimulus(4'h0, 1'b1);
    tick(6);
    checkOutput("s1_release_out", sw_if.switch_out, 4'h0);
    checkOutput("s1_release_fall", sw_if.fall, EDGE ? 4'hF : 4'h0);
    checkOutput("s1_release_rise", sw_if.rise, 4'h0);
    tick(1);

    // Scenario 2: clean press on two bits at once
    applyStimulus(4'h6, 1'b1);
    tick(5);
    checkOutput("s2_before_accept", sw_if.switch_out, 4'h0);
    checkOutput("s2_no_early_rise", sw_if.rise, 4'h0);
    tick(1);
    checkOutput("s2_switch_out", sw_if.switch_out, 4'h6);
    checkOutput("s2_rise", sw_if.rise, EDGE ? 4'h6 : 4'h0);
    checkOutput("s2_fall", sw_if.fall, 4'h0);
    checkOutput("s2_changed", sw_if.changed, EDGE);
    tick(1);
    checkOutput("s2_rise_cleared", sw_if.rise, 4'h0);
    checkOutput("s2_changed_cleared", sw_if.changed, 1'b0);
    checkOutput("s2_level_held", sw_if.switch_out, 4'h6);

    applyStimulus(4'h0, 1'b1);
    tick(8);
    checkOutput("s2_released", sw_if.switch_out, 4'h0);

    // Scenario 3: 3-cycle glitch on bit0 must be rejected
    seen_out  = '0;
    seen_rise = '0;
    applyStimulus(4'h1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      seen_out  |= sw_if.switch_out;
      seen_rise |= sw_if.rise;
    end
    applyStimulus(4'h0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      seen_out  |= sw_if.switch_out;
      seen_rise |= sw_if.rise;
    end
    checkOutput("s3_glitch_out", seen_out, 4'h0);
    checkOutput("s3_glitch_rise", seen_rise, 4'h0);

    // Scenario 4: bit1 bounces every cycle for 20 cycles, then held high
    rise_count = 0;
    rise_step  = 0;
    out_step   = 0;
    seen_out   = '0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus((k % 2 == 0) ? 4'h2 : 4'h0, 1'b1);
      tick(1);
      seen_out |= sw_if.switch_out;
      if (sw_if.rise[1]) rise_count++;
    end
    checkOutput("s4_bounce_hold", seen_out, 4'h0);
    applyStimulus(4'h2, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (sw_if.rise[1]) begin
        rise_count++;
        rise_step = k;
      end
      if (sw_if.switch_out[1] && out_step == 0) out_step = k;
    end
    checkOutput("s4_out_latency", out_step, 6);
    checkOutput("s4_rise_count", rise_count, EDGE ? 1 : 0);
    checkOutput("s4_rise_latency", rise_step, EDGE ? 6 : 0);
    checkOutput("s4_final_out", sw_if.switch_out, 4'h2);

    // Scenario 5: bit2 release interrupted by reset mid-count
    applyStimulus(4'h0, 1'b1);
    tick(8);
    applyStimulus(4'h4, 1'b1);
    tick(8);
    checkOutput("s5_setup_out", sw_if.switch_out, 4'h4);
    seen_fall = '0;
    applyStimulus(4'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      seen_fall |= sw_if.fall;
    end
    applyStimulus(4'h0, 1'b0);
    tick(1);
    applyStimulus(4'h0, 1'b1);
    checkOutput("s5_reset_out", sw_if.switch_out, 4'h0);
    checkOutput("s5_reset_rise", sw_if.rise, 4'h0);
    checkOutput("s5_reset_fall", sw_if.fall, 4'h0);
    checkOutput("s5_reset_changed", sw_if.changed, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      seen_fall |= sw_if.fall;
    end
    checkOutput("s5_no_fall", seen_fall, 4'h0);
    checkOutput("s5_after_out", sw_if.switch_out, 4'h0);

    // Scenario 5b: press interrupted by reset; partial count must be lost
    applyStimulus(4'h4, 1'b1);
    tick(4);
    applyStimulus(4'h4, 1'b0);
    tick(1);
    applyStimulus(4'h4, 1'b1);
    checkOutput("s5b_reset_out", sw_if.switch_out, 4'h0);
    out_step = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (sw_if.switch_out[2] && out_step == 0) out_step = k;
    end
    checkOutput("s5b_full_latency", out_step, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
